// File: rtl/load_store_unit.sv
// Purpose: M-stage load/store unit; runs a req/gnt/rvalid handshake with a variable-latency
//          data memory and returns the lane-extracted, sign/zero-extended load result.
// Latency: store = 2 stall cycles, load = 3 stall cycles (+1 per cycle of gnt/rvalid delay),
//          misaligned/illegal = 1 stall cycle.
// Backpressure: dmem_req is held with stable fields until dmem_gnt; StallM freezes the
//          pipeline until the DONE cycle.
//
// Ports:
//   clk, reset                    pipeline clock, async active-high reset
//   MemValidM, MemWriteM, Funct3M  M-stage access control (load/store, width/sign code)
//   ALUResultM, WriteDataM         byte address and right-aligned store data
//   StallM                         combinational stall to the hazard unit
//   ReadDataM, MisalignM           registered load result and misalign/illegal pulse
//   dmem_*                         data memory request/grant/response channel
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemValidM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            StallM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            MisalignM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, state_next;

    // Offset and width code of the outstanding access, kept for load extraction
    logic [1:0] off_q;
    logic [2:0] f3_q;

    logic            access_ok;
    logic            start_legal;
    logic            start_illegal;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] rd_ext;

    // ------------------------------------------------------------------
    // Access legality: alignment per width, plus unused funct3 codes.
    // Unsigned variants (4, 5) exist only for loads.
    // ------------------------------------------------------------------
    always_comb begin
        access_ok = 1'b0;
        case (Funct3M)
            3'd0:    access_ok = 1'b1;
            3'd1:    access_ok = ~ALUResultM[0];
            3'd2:    access_ok = (ALUResultM[1:0] == 2'b00);
            3'd4:    access_ok = ~MemWriteM;
            3'd5:    access_ok = ~MemWriteM & ~ALUResultM[0];
            default: access_ok = 1'b0;
        endcase
    end

    assign start_legal   = (state == IDLE) && MemValidM &&  access_ok;
    assign start_illegal = (state == IDLE) && MemValidM && !access_ok;

    // ------------------------------------------------------------------
    // Byte enables and lane-replicated write data. Computed for loads as
    // well so the memory sees which lanes the load actually consumes.
    // ------------------------------------------------------------------
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = WriteDataM;
        case (Funct3M[1:0])
            2'd0: begin
                be_next    = 4'b0001 << ALUResultM[1:0];
                wdata_next = {4{WriteDataM[7:0]}};
            end
            2'd1: begin
                be_next    = 4'b0011 << {ALUResultM[1], 1'b0};
                wdata_next = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = WriteDataM;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane extraction from the latched offset, then extension.
    // ------------------------------------------------------------------
    always_comb begin
        rd_byte = dmem_rdata[7:0];
        case (off_q)
            2'd0: rd_byte = dmem_rdata[7:0];
            2'd1: rd_byte = dmem_rdata[15:8];
            2'd2: rd_byte = dmem_rdata[23:16];
            2'd3: rd_byte = dmem_rdata[31:24];
            default: rd_byte = dmem_rdata[7:0];
        endcase
        rd_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    end

    always_comb begin
        rd_ext = dmem_rdata;
        case (f3_q)
            3'd0:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    rd_ext = {{16{rd_half[15]}}, rd_half};
            3'd4:    rd_ext = {24'h0, rd_byte};
            3'd5:    rd_ext = {16'h0, rd_half};
            default: rd_ext = dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (MemValidM) begin
                    state_next = access_ok ? REQ : DONE;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    state_next = dmem_we ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded from state so a mid-access reset drops the request at once
    assign dmem_req = (state == REQ);
    assign StallM   = MemValidM & (state != DONE);

    // ------------------------------------------------------------------
    // Request fields: captured once in IDLE and held through REQ/WAIT_R,
    // so M-stage input changes while stalled cannot disturb the access.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
        end else if (start_legal) begin
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ALUResultM[XLEN-1:2], 2'b00};
            dmem_be    <= be_next;
            dmem_wdata <= wdata_next;
            off_q      <= ALUResultM[1:0];
            f3_q       <= Funct3M;
        end
    end

    // ------------------------------------------------------------------
    // Result and misalign pulse. MisalignM is set on the IDLE->DONE hop
    // and therefore is high only in the DONE cycle. rvalid is honoured
    // only in WAIT_R, so a response to an abandoned request is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ReadDataM <= '0;
            MisalignM <= 1'b0;
        end else begin
            MisalignM <= start_illegal;
            if (start_illegal) begin
                ReadDataM <= '0;
            end else if ((state == WAIT_R) && dmem_rvalid) begin
                ReadDataM <= rd_ext;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemValidM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemValidM  (MemValidM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .MisalignM  (MisalignM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] rd;
        int          mis_cnt;
        int          stalls;
        logic        req_seen;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } txn_t;

    txn_t exp_q[$];

    // Drive one access, act as the memory (gnt after gnt_dly REQ cycles,
    // rvalid rv_dly cycles after the cycle following gnt) and record what the
    // DUT did. Leaves MemValidM asserted; the caller releases or chains.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                              input logic [31:0] rdata, output txn_t obs);
        int  req_cycles = 0;
        int  rv_wait = 0;
        bit  rv_pending = 0;
        bit  done = 0;
        obs = '{default: 0};
        MemValidM  = 1'b1;
        MemWriteM  = we;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = 32'h0;
            if (rv_pending) begin
                if (rv_wait == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                    rv_pending  = 0;
                end else begin
                    rv_wait--;
                end
            end
            if (dmem_req) begin
                if (req_cycles == gnt_dly) begin
                    dmem_gnt  = 1'b1;
                    obs.addr  = dmem_addr;
                    obs.be    = dmem_be;
                    obs.wdata = dmem_wdata;
                    obs.we    = dmem_we;
                    if (!we) begin
                        rv_pending = 1;
                        rv_wait    = rv_dly;
                    end
                end else begin
                    // pipeline is frozen, but scribble the inputs anyway:
                    // the latched request must not follow them
                    ALUResultM = ~addr;
                    WriteDataM = ~wd;
                end
                req_cycles++;
            end
            #1;
            obs.req_seen = obs.req_seen | dmem_req;
            obs.mis_cnt += int'(MisalignM);
            if (StallM) obs.stalls++;
            else begin
                done   = 1;
                obs.rd = ReadDataM;
            end
            @(posedge clk);
            #1;
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL access_timeout addr=%h: StallM never dropped within 100 cycles", addr);
        end
        obs.mis_cnt += int'(MisalignM);
    endtask

    task automatic release_m();
        MemValidM = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        txn_t o, e;
        reset = 1'b1;
        MemValidM = 0; MemWriteM = 0; Funct3M = 0; ALUResultM = 0; WriteDataM = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ReadDataM, MisalignM, StallM} !== '0) begin
            fails++;
            $display("FAIL reset_values got req=%b we=%b addr=%h be=%b wdata=%h rd=%h mis=%b stall=%b want all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ReadDataM, MisalignM, StallM);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        // LW 0x40, memory withholds gnt
        MemValidM = 1; MemWriteM = 0; Funct3M = 3'd2; ALUResultM = 32'h40;
        @(posedge clk);
        #1;
        tests++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h40) begin
            fails++;
            $display("FAIL reset_pre_req got req=%b addr=%h want req=1 addr=00000040", dmem_req, dmem_addr);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ReadDataM, MisalignM} !== '0) begin
            fails++;
            $display("FAIL reset_mid_access got req=%b we=%b addr=%h be=%b wdata=%h rd=%h mis=%b want all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, ReadDataM, MisalignM);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        MemValidM = 0;
        // late response to the abandoned request
        dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        dmem_rvalid = 0;
        tests++;
        if (ReadDataM !== 32'h0 || dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_stale_rvalid got rd=%h req=%b want rd=00000000 req=0", ReadDataM, dmem_req);
        end
        // FSM back in IDLE: a fresh SW must take exactly 2 stall cycles
        exp_q.push_back('{rd: 32'h0, mis_cnt: 0, stalls: 2, req_seen: 1, addr: 32'h44,
                          be: 4'hF, wdata: 32'h1111_2222, we: 1});
        run_access(1, 3'd2, 32'h44, 32'h1111_2222, 0, 0, 32'h0, o);
        release_m();
        e = exp_q.pop_front();
        tests++;
        if (o.stalls !== e.stalls || o.addr !== e.addr || o.wdata !== e.wdata) begin
            fails++;
            $display("FAIL reset_then_sw got stalls=%0d addr=%h wdata=%h want stalls=%0d addr=%h wdata=%h",
                     o.stalls, o.addr, o.wdata, e.stalls, e.addr, e.wdata);
        end
    endtask

    task automatic test_store_byte();
        txn_t o, e;
        exp_q.push_back('{rd: 32'h0, mis_cnt: 0, stalls: 2, req_seen: 1, addr: 32'h100,
                          be: 4'b1000, wdata: 32'hABAB_ABAB, we: 1});
        run_access(1, 3'd0, 32'h0000_0103, 32'h1234_56AB, 0, 0, 32'h0, o);
        release_m();
        e = exp_q.pop_front();
        tests++;
        if (o.addr !== e.addr || o.be !== e.be || o.wdata !== e.wdata || o.we !== e.we) begin
            fails++;
            $display("FAIL sb_request got addr=%h be=%b wdata=%h we=%b want addr=%h be=%b wdata=%h we=%b",
                     o.addr, o.be, o.wdata, o.we, e.addr, e.be, e.wdata, e.we);
        end
        tests++;
        if (o.stalls !== e.stalls || o.rd !== e.rd || o.mis_cnt !== e.mis_cnt) begin
            fails++;
            $display("FAIL sb_timing got stalls=%0d rd=%h mis=%0d want stalls=%0d rd=%h mis=%0d",
                     o.stalls, o.rd, o.mis_cnt, e.stalls, e.rd, e.mis_cnt);
        end
    endtask

    task automatic test_load_byte();
        txn_t o, e;
        exp_q.push_back('{rd: 32'hFFFF_FF80, mis_cnt: 0, stalls: 5, req_seen: 1, addr: 32'h200,
                          be: 4'b0100, wdata: 32'h0, we: 0});
        run_access(0, 3'd0, 32'h202, 32'h0, 2, 0, 32'h0080_0000, o);
        release_m();
        e = exp_q.pop_front();
        tests++;
        if (o.rd !== e.rd || o.stalls !== e.stalls) begin
            fails++;
            $display("FAIL lb_delayed got rd=%h stalls=%0d want rd=%h stalls=%0d", o.rd, o.stalls, e.rd, e.stalls);
        end
        tests++;
        if (o.addr !== e.addr || o.be !== e.be || o.we !== e.we) begin
            fails++;
            $display("FAIL lb_request got addr=%h be=%b we=%b want addr=%h be=%b we=%b",
                     o.addr, o.be, o.we, e.addr, e.be, e.we);
        end
    endtask

    task automatic test_load_half();
        txn_t o, e;
        logic [2:0] f3s [2];
        logic [31:0] exps [2];
        f3s[0] = 3'd5; exps[0] = 32'h0000_BEEF;
        f3s[1] = 3'd1; exps[1] = 32'hFFFF_BEEF;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{rd: exps[i], mis_cnt: 0, stalls: 3, req_seen: 1, addr: 32'h300,
                              be: 4'b1100, wdata: 32'h0, we: 0});
            run_access(0, f3s[i], 32'h302, 32'h0, 0, 0, 32'hBEEF_1234, o);
            release_m();
            e = exp_q.pop_front();
            tests++;
            if (o.rd !== e.rd || o.be !== e.be || o.stalls !== e.stalls) begin
                fails++;
                $display("FAIL lh_f3_%0d got rd=%h be=%b stalls=%0d want rd=%h be=%b stalls=%0d",
                         f3s[i], o.rd, o.be, o.stalls, e.rd, e.be, e.stalls);
            end
        end
    endtask

    task automatic test_lanes();
        txn_t o, e;
        logic [2:0]  f3s [4];
        logic [31:0] adrs [4];
        logic [31:0] rds [4];
        logic [31:0] exps [4];
        int          rvd [4];
        f3s[0] = 3'd4; adrs[0] = 32'h201; rds[0] = 32'h1234_5678; exps[0] = 32'h0000_0056; rvd[0] = 0;
        f3s[1] = 3'd0; adrs[1] = 32'h203; rds[1] = 32'h80FF_0000; exps[1] = 32'hFFFF_FF80; rvd[1] = 2;
        f3s[2] = 3'd1; adrs[2] = 32'h300; rds[2] = 32'h0000_8001; exps[2] = 32'hFFFF_8001; rvd[2] = 0;
        f3s[3] = 3'd2; adrs[3] = 32'h404; rds[3] = 32'h89AB_CDEF; exps[3] = 32'h89AB_CDEF; rvd[3] = 1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{rd: exps[i], mis_cnt: 0, stalls: 3 + rvd[i], req_seen: 1, addr: 32'h0,
                              be: 4'h0, wdata: 32'h0, we: 0});
            run_access(0, f3s[i], adrs[i], 32'h0, 0, rvd[i], rds[i], o);
            release_m();
            e = exp_q.pop_front();
            tests++;
            if (o.rd !== e.rd || o.stalls !== e.stalls) begin
                fails++;
                $display("FAIL lane_%0d got rd=%h stalls=%0d want rd=%h stalls=%0d",
                         i, o.rd, o.stalls, e.rd, e.stalls);
            end
        end
    endtask

    task automatic test_misalign();
        txn_t o, e;
        logic        wes  [5];
        logic [2:0]  f3s  [5];
        logic [31:0] adrs [5];
        wes[0] = 0; f3s[0] = 3'd2; adrs[0] = 32'h401;
        wes[1] = 1; f3s[1] = 3'd1; adrs[1] = 32'h11;
        wes[2] = 1; f3s[2] = 3'd3; adrs[2] = 32'h20;
        wes[3] = 0; f3s[3] = 3'd6; adrs[3] = 32'h20;
        wes[4] = 1; f3s[4] = 3'd4; adrs[4] = 32'h20;
        for (int i = 0; i < 5; i++) begin
            // leave a nonzero ReadDataM so the zeroing is observable
            run_access(0, 3'd2, 32'h500, 32'h0, 0, 0, 32'h5A5A_0F0F, o);
            release_m();
            exp_q.push_back('{rd: 32'h0, mis_cnt: 1, stalls: 1, req_seen: 0, addr: 32'h0,
                              be: 4'h0, wdata: 32'h0, we: 0});
            run_access(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, 0, 0, 32'h0, o);
            release_m();
            e = exp_q.pop_front();
            tests++;
            if (o.rd !== e.rd || o.mis_cnt !== e.mis_cnt || o.stalls !== e.stalls || o.req_seen !== e.req_seen) begin
                fails++;
                $display("FAIL misalign_%0d got rd=%h mis_pulses=%0d stalls=%0d req=%b want rd=%h mis_pulses=%0d stalls=%0d req=%b",
                         i, o.rd, o.mis_cnt, o.stalls, o.req_seen, e.rd, e.mis_cnt, e.stalls, e.req_seen);
            end
        end
    endtask

    task automatic test_back_to_back();
        txn_t o1, o2, o3, e;
        // SH, SW, LW chained with no idle cycle between them
        exp_q.push_back('{rd: 32'h0, mis_cnt: 0, stalls: 2, req_seen: 1, addr: 32'h10,
                          be: 4'b1100, wdata: 32'hBEEF_BEEF, we: 1});
        exp_q.push_back('{rd: 32'h0, mis_cnt: 0, stalls: 3, req_seen: 1, addr: 32'h10,
                          be: 4'b1111, wdata: 32'hCAFE_F00D, we: 1});
        exp_q.push_back('{rd: 32'hCAFE_F00D, mis_cnt: 0, stalls: 3, req_seen: 1, addr: 32'h10,
                          be: 4'b1111, wdata: 32'h0, we: 0});
        run_access(1, 3'd1, 32'h12, 32'h0000_BEEF, 0, 0, 32'h0, o1);
        run_access(1, 3'd2, 32'h10, 32'hCAFE_F00D, 1, 0, 32'h0, o2);
        run_access(0, 3'd2, 32'h10, 32'h0, 0, 0, o2.wdata, o3);
        release_m();
        e = exp_q.pop_front();
        tests++;
        if (o1.be !== e.be || o1.wdata !== e.wdata || o1.addr !== e.addr || o1.stalls !== e.stalls) begin
            fails++;
            $display("FAIL b2b_sh got be=%b wdata=%h addr=%h stalls=%0d want be=%b wdata=%h addr=%h stalls=%0d",
                     o1.be, o1.wdata, o1.addr, o1.stalls, e.be, e.wdata, e.addr, e.stalls);
        end
        e = exp_q.pop_front();
        tests++;
        if (o2.be !== e.be || o2.wdata !== e.wdata || o2.stalls !== e.stalls) begin
            fails++;
            $display("FAIL b2b_sw got be=%b wdata=%h stalls=%0d want be=%b wdata=%h stalls=%0d",
                     o2.be, o2.wdata, o2.stalls, e.be, e.wdata, e.stalls);
        end
        e = exp_q.pop_front();
        tests++;
        if (o3.rd !== e.rd || o3.stalls !== e.stalls || o3.we !== e.we) begin
            fails++;
            $display("FAIL b2b_lw got rd=%h stalls=%0d we=%b want rd=%h stalls=%0d we=%b",
                     o3.rd, o3.stalls, o3.we, e.rd, e.stalls, e.we);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d entries left want 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_byte();
        test_load_byte();
        test_load_half();
        test_lanes();
        test_misalign();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the five-stage RV32I pipeline. Consumes the M-stage operands (ALUResultM as the address, WriteDataM, MemWriteM, funct3) and runs a request/grant/response handshake with a variable-latency data memory. It produces the lane-aligned and extended ReadDataM for the write-back register. While an access is outstanding it raises StallM so the hazard unit freezes the pipeline.

## Interface

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- MemValidM  input  1  the instruction in M is a load or a store
- MemWriteM  input  1  1 = store, 0 = load (meaningful only when MemValidM=1)
- Funct3M  input  3  RV32I width/sign code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2)
- ALUResultM  input  XLEN  byte address
- WriteDataM  input  XLEN  store data, right-aligned
- StallM  output  1  combinational; 1 while the M access is not complete
- ReadDataM  output  XLEN  registered, extended load result
- MisalignM  output  1  registered one-cycle pulse for a misaligned or illegal access
- dmem_req  output  1  request valid; held until granted
- dmem_we  output  1  write enable for the request
- dmem_addr  output  XLEN  word address; bits [1:0] are always 0
- dmem_be  output  4  byte enables
- dmem_wdata  output  XLEN  lane-replicated store data
- dmem_gnt  input  1  request accepted in this cycle
- dmem_rvalid  input  1  load data valid; never asserted in the same cycle as its gnt
- dmem_rdata  input  XLEN  load word

## Operation

- FSM states: IDLE, REQ, WAIT_R, DONE. Reset state is IDLE.
- IDLE, MemValidM=0: stay in IDLE. dmem_rvalid is ignored in IDLE.
- IDLE, MemValidM=1, legal and aligned access:
  - latch addr = {ALUResultM[31:2],2'b00}, be, wdata and we; go to REQ.
  - The latched address offset ALUResultM[1:0] and Funct3M are also kept for load extraction.
- IDLE, MemValidM=1, misaligned or illegal access:
  - A misaligned or illegal access is any of: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0; load funct3 ∈ {3,6,7}; store funct3 ≥ 3.
  - Pulse MisalignM, set ReadDataM=0 and go to DONE. No memory request is issued.
- REQ: dmem_req=1 with stable addr, be, wdata and we until gnt.
  - On gnt, a store goes to DONE and a load goes to WAIT_R.
- WAIT_R: on dmem_rvalid, load ReadDataM with the extracted lane and go to DONE.
- DONE: StallM=0 and the pipeline advances. Next state is unconditionally IDLE.
- StallM = MemValidM & (state≠DONE).
- Store byte enables:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{WriteDataM[7:0]}}.
  - SH: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{WriteDataM[15:0]}}.
  - SW: be = 4'b1111, wdata = WriteDataM.
- Load extraction uses the latched offset.
  - Byte = rdata[8*off+:8]; half = rdata[16*off[1]+:16].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Latched request fields are not affected by changes on the M inputs while in REQ/WAIT_R, because the pipeline is stalled.

## Timing

- Reset values: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, ReadDataM=0, MisalignM=0, state=IDLE.
- Reset asserted mid-access (REQ or WAIT_R): the state returns to IDLE and dmem_req drops asynchronously. Any later rvalid from the abandoned request is ignored.
- Store, gnt on the first REQ cycle: 2 stall cycles (IDLE, REQ), with DONE in the 3rd cycle.
- Load, gnt on the first REQ cycle and rvalid one cycle later: 3 stall cycles, with DONE in the 4th cycle.
- Each cycle of gnt or rvalid delay adds one stall cycle. There is no timeout.
- Misaligned or illegal access: 1 stall cycle. MisalignM is high in the DONE cycle only.
- ReadDataM is valid in the DONE cycle and holds until the next load completes or the next misaligned/illegal access zeroes it. The M/W register samples it at the end of DONE.
- Back-to-back accesses: the next instruction reaches M in the cycle after DONE while the FSM is in IDLE, so there is no overlap.

## Test plan

- Reset: assert reset during a REQ with dmem_gnt=0 -> dmem_req=0 immediately; every output takes its reset value; after reset deassertion the FSM is in IDLE.
- SB to 0x0000_0103 with WriteDataM=0x1234_56AB, gnt at once -> dmem_addr=0x100, be=4'b1000, wdata=0xABAB_ABAB; StallM high for 2 cycles.
- LB from 0x202 with rdata=0x0080_0000, gnt delayed 2 cycles, rvalid 1 cycle after gnt -> ReadDataM=0xFFFF_FF80; 5 stall cycles.
- LHU from 0x302 with rdata=0xBEEF_1234 -> be=4'b1100, ReadDataM=0x0000_BEEF. LH from the same address and data -> ReadDataM=0xFFFF_BEEF.
- LW from 0x401 -> MisalignM pulses once, dmem_req never rises, ReadDataM=0, StallM high for 1 cycle.
- Back-to-back SW 0x10 then LW 0x10, with memory returning the stored data -> ReadDataM equals the stored word and StallM deasserts once per access.
